// File: rtl/snake_direction_scheduler.sv
// snake_direction_scheduler
//   Converts debounced push-button levels into a FIFO of snake heading
//   changes. One queued change is applied to the heading per game tick.
//   Simultaneous presses are arbitrated round-robin. Presses on the same
//   axis as the reference heading (repeat or 180-degree reversal) are
//   silently rejected.
// Ports
//   i_Clk          system clock
//   i_Rst_n        asynchronous active-low reset
//   i_Buttons[3:0] debounced levels: [0] up, [1] down, [2] left, [3] right
//   i_Enable       game running; low flushes the queue and ignores input
//   i_Restart      1-cycle new-game strobe (highest priority)
//   i_Tick         1-cycle game-step strobe
//   o_Dir          current heading (00 up, 01 down, 10 left, 11 right)
//   o_Dir_Update   1-cycle pulse when o_Dir changed
//   o_Count        FIFO occupancy
//   o_Overflow     1-cycle pulse when an accepted press hit a full FIFO
module snake_direction_scheduler #(
  parameter int         c_QUEUE_DEPTH = 4,
  parameter logic [1:0] c_INIT_DIR    = 2'b11
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst_n,
  input  logic [3:0]                       i_Buttons,
  input  logic                             i_Enable,
  input  logic                             i_Restart,
  input  logic                             i_Tick,
  output logic [1:0]                       o_Dir,
  output logic                             o_Dir_Update,
  output logic [$clog2(c_QUEUE_DEPTH):0]   o_Count,
  output logic                             o_Overflow
);

  localparam int c_PW = $clog2(c_QUEUE_DEPTH);
  localparam int c_CW = c_PW + 1;

  logic [3:0]      r_Prev;
  logic [1:0]      r_Rr_Ptr;
  logic [1:0]      r_Dir;
  logic            r_Dir_Update;
  logic            r_Overflow;
  logic [c_CW-1:0] r_Count;
  logic [c_PW-1:0] r_Wr_Ptr;
  logic [c_PW-1:0] r_Rd_Ptr;
  logic [1:0]      r_Mem [c_QUEUE_DEPTH];

  logic [3:0]      w_Press;
  logic            w_Grant_Valid;
  logic [1:0]      w_Grant;
  logic [c_PW-1:0] w_Tail_Ptr;
  logic [1:0]      w_Ref;
  logic            w_Live;
  logic            w_Accept;
  logic            w_Full;
  logic            w_Push;
  logic            w_Pop;

  assign w_Press = i_Buttons & ~r_Prev;

  // Search starts at the RR pointer and wraps 3 -> 0; first hit wins.
  always_comb begin
    logic [1:0] v_idx;
    v_idx         = '0;
    w_Grant_Valid = 1'b0;
    w_Grant       = '0;
    for (int i = 0; i < 4; i++) begin
      v_idx = r_Rr_Ptr + 2'(i);
      if (!w_Grant_Valid && w_Press[v_idx]) begin
        w_Grant_Valid = 1'b1;
        w_Grant       = v_idx;
      end
    end
  end

  // Reference is the newest queued heading, or the live heading when empty.
  // Same-axis directions differ only in bit 0, so one compare covers both
  // the repeat and the reversal case.
  assign w_Tail_Ptr = r_Wr_Ptr - c_PW'(1);
  assign w_Ref      = (r_Count != '0) ? r_Mem[w_Tail_Ptr] : r_Dir;
  assign w_Live     = i_Enable & ~i_Restart;
  assign w_Accept   = w_Live & w_Grant_Valid & (w_Grant[1] != w_Ref[1]);
  assign w_Full     = (r_Count == c_CW'(c_QUEUE_DEPTH));
  assign w_Push     = w_Accept & ~w_Full;
  assign w_Pop      = w_Live & i_Tick & (r_Count != '0);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Prev       <= 4'b1111;
      r_Rr_Ptr     <= '0;
      r_Dir        <= c_INIT_DIR;
      r_Dir_Update <= 1'b0;
      r_Overflow   <= 1'b0;
      r_Count      <= '0;
      r_Wr_Ptr     <= '0;
      r_Rd_Ptr     <= '0;
      for (int i = 0; i < c_QUEUE_DEPTH; i++) r_Mem[i] <= '0;
    end else begin
      r_Prev       <= i_Buttons;
      r_Dir_Update <= 1'b0;
      r_Overflow   <= w_Accept & w_Full;
      if (i_Restart) begin
        r_Dir        <= c_INIT_DIR;
        r_Dir_Update <= (r_Dir != c_INIT_DIR);
        r_Rr_Ptr     <= '0;
        r_Count      <= '0;
        r_Wr_Ptr     <= '0;
        r_Rd_Ptr     <= '0;
      end else if (!i_Enable) begin
        r_Count  <= '0;
        r_Wr_Ptr <= '0;
        r_Rd_Ptr <= '0;
      end else begin
        if (w_Grant_Valid) r_Rr_Ptr <= w_Grant + 2'd1;
        if (w_Push) begin
          r_Mem[r_Wr_Ptr] <= w_Grant;
          r_Wr_Ptr        <= r_Wr_Ptr + c_PW'(1);
        end
        if (w_Pop) begin
          r_Dir        <= r_Mem[r_Rd_Ptr];
          r_Dir_Update <= 1'b1;
          r_Rd_Ptr     <= r_Rd_Ptr + c_PW'(1);
        end
        case ({w_Push, w_Pop})
          2'b10:   r_Count <= r_Count + c_CW'(1);
          2'b01:   r_Count <= r_Count - c_CW'(1);
          default: r_Count <= r_Count;
        endcase
      end
    end
  end

  assign o_Dir        = r_Dir;
  assign o_Dir_Update = r_Dir_Update;
  assign o_Count      = r_Count;
  assign o_Overflow   = r_Overflow;

endmodule

// File: tb/tb_snake_direction_scheduler.sv
module tb_snake_direction_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic       en, rs, tk;
  logic [1:0] dir;
  logic       upd;
  logic [2:0] cnt;
  logic       ovf;

  always #5 clk = ~clk;

  snake_direction_scheduler #(.c_QUEUE_DEPTH(4), .c_INIT_DIR(2'b11)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Buttons(btn), .i_Enable(en),
    .i_Restart(rs), .i_Tick(tk), .o_Dir(dir), .o_Dir_Update(upd),
    .o_Count(cnt), .o_Overflow(ovf)
  );

  typedef struct {
    logic [3:0] b;
    logic       en, rs, tk;
    logic [1:0] d;
    logic       u;
    logic [2:0] c;
    logic       o;
  } vec_t;

  typedef struct {
    logic [1:0] d;
    logic       u;
    logic [2:0] c;
    logic       o;
    int         idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] b, input logic e, input logic r, input logic t,
                     input logic [1:0] d, input logic u, input logic [2:0] c, input logic o);
    vec_t v;
    v.b = b; v.en = e; v.rs = r; v.tk = t; v.d = d; v.u = u; v.c = c; v.o = o;
    tbl.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] d, input logic u,
                               input logic [2:0] c, input logic o);
    chk({tag, " dir"},  8'(dir), 8'(d));
    chk({tag, " upd"},  8'(upd), 8'(u));
    chk({tag, " cnt"},  8'(cnt), 8'(c));
    chk({tag, " ovf"},  8'(ovf), 8'(o));
  endtask

  // Drive one vector at the falling edge, queue its expectation, and check
  // it one time unit after the following rising edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    btn = v.b; en = v.en; rs = v.rs; tk = v.tk;
    e.d = v.d; e.u = v.u; e.c = v.c; e.o = v.o; e.idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_assert++; n_fail++;
      $display("FAIL scoreboard v%0d: got empty queue expected entry", idx);
    end else begin
      e = sb.pop_front();
      check_outputs($sformatf("v%0d", e.idx), e.d, e.u, e.c, e.o);
    end
  endtask

  initial begin
    // btn   en rs tk | dir upd cnt ovf
    // held-through-reset press is ignored
    add(4'b0001, 1, 0, 0, 2'd3, 0, 3'd0, 0);
    add(4'b0000, 1, 0, 0, 2'd3, 0, 3'd0, 0);
    // up accepted, tick applies it, second tick does nothing
    add(4'b0001, 1, 0, 0, 2'd3, 0, 3'd1, 0);
    add(4'b0000, 1, 0, 1, 2'd0, 1, 3'd0, 0);
    add(4'b0000, 1, 0, 1, 2'd0, 0, 3'd0, 0);
    add(4'b0000, 1, 0, 0, 2'd0, 0, 3'd0, 0);
    // restart changes heading back to right, pulses update
    add(4'b0000, 1, 1, 0, 2'd3, 1, 3'd0, 0);
    add(4'b0000, 1, 0, 0, 2'd3, 0, 3'd0, 0);
    // left (reversal) and right (repeat) rejected
    add(4'b0100, 1, 0, 0, 2'd3, 0, 3'd0, 0);
    add(4'b0000, 1, 0, 0, 2'd3, 0, 3'd0, 0);
    add(4'b1000, 1, 0, 0, 2'd3, 0, 3'd0, 0);
    add(4'b0000, 1, 0, 0, 2'd3, 0, 3'd0, 0);
    // round robin: up+left -> up, then up+left -> left
    add(4'b0101, 1, 0, 0, 2'd3, 0, 3'd1, 0);
    add(4'b0000, 1, 0, 0, 2'd3, 0, 3'd1, 0);
    add(4'b0101, 1, 0, 0, 2'd3, 0, 3'd2, 0);
    add(4'b0000, 1, 0, 0, 2'd3, 0, 3'd2, 0);
    // restart without heading change: no pulse, flush
    add(4'b0000, 1, 1, 0, 2'd3, 0, 3'd0, 0);
    // fill to depth 4, fifth press overflows
    add(4'b0001, 1, 0, 0, 2'd3, 0, 3'd1, 0);
    add(4'b0000, 1, 0, 0, 2'd3, 0, 3'd1, 0);
    add(4'b0100, 1, 0, 0, 2'd3, 0, 3'd2, 0);
    add(4'b0000, 1, 0, 0, 2'd3, 0, 3'd2, 0);
    add(4'b0001, 1, 0, 0, 2'd3, 0, 3'd3, 0);
    add(4'b0000, 1, 0, 0, 2'd3, 0, 3'd3, 0);
    add(4'b0100, 1, 0, 0, 2'd3, 0, 3'd4, 0);
    add(4'b0000, 1, 0, 0, 2'd3, 0, 3'd4, 0);
    add(4'b0001, 1, 0, 0, 2'd3, 0, 3'd4, 1);
    add(4'b0000, 1, 0, 0, 2'd3, 0, 3'd4, 0);
    // drain in order, then push down while popping
    add(4'b0000, 1, 0, 1, 2'd0, 1, 3'd3, 0);
    add(4'b0000, 1, 0, 1, 2'd2, 1, 3'd2, 0);
    add(4'b0010, 1, 0, 1, 2'd0, 1, 3'd2, 0);
    add(4'b0000, 1, 0, 0, 2'd0, 0, 3'd2, 0);
    // three queued, restart with tick wins
    add(4'b1000, 1, 0, 0, 2'd0, 0, 3'd3, 0);
    add(4'b0000, 1, 0, 0, 2'd0, 0, 3'd3, 0);
    add(4'b0000, 1, 1, 1, 2'd3, 1, 3'd0, 0);
    add(4'b0000, 1, 0, 1, 2'd3, 0, 3'd0, 0);
    // queue two, disable flushes and ignores tick/press
    add(4'b0001, 1, 0, 0, 2'd3, 0, 3'd1, 0);
    add(4'b0000, 1, 0, 0, 2'd3, 0, 3'd1, 0);
    add(4'b0100, 1, 0, 0, 2'd3, 0, 3'd2, 0);
    add(4'b0000, 1, 0, 0, 2'd3, 0, 3'd2, 0);
    add(4'b0000, 0, 0, 1, 2'd3, 0, 3'd0, 0);
    add(4'b0001, 0, 0, 0, 2'd3, 0, 3'd0, 0);
    // button still held after re-enable: history tracked, no press
    add(4'b0001, 1, 0, 0, 2'd3, 0, 3'd0, 0);
    add(4'b0000, 1, 0, 0, 2'd3, 0, 3'd0, 0);
    // press coincident with restart is discarded
    add(4'b0001, 1, 1, 0, 2'd3, 0, 3'd0, 0);
    add(4'b0000, 1, 0, 0, 2'd3, 0, 3'd0, 0);

    rst_n = 1'b0; btn = 4'b0001; en = 1'b1; rs = 1'b0; tk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 2'd3, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

    // Asynchronous reset mid-cycle with an entry queued and up held.
    begin
      vec_t v;
      v.b = 4'b0001; v.en = 1; v.rs = 0; v.tk = 0; v.d = 2'd3; v.u = 0; v.c = 3'd1; v.o = 0;
      apply(v, 100);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_outputs("async_rst", 2'd3, 1'b0, 3'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      v.c = 3'd0;
      apply(v, 101);
    end

    if (sb.size() != 0) begin
      n_assert++; n_fail++;
      $display("FAIL scoreboard_left: got %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
